// File: rtl/sbox6_iter_engine.sv
// Multi-lane iterated 6-bit power-map S-box engine: each lane computes S^k(x), one application per clock.
// Optional abort input is enabled by defining SBOX6_ABORT_EN.
module sbox6_iter_engine #(
    parameter int LANES = 4,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6*LANES-1:0]   in_data,
    input  logic [CNT_W-1:0]     in_rounds,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6*LANES-1:0]   out_data,
    output logic                 busy
`ifdef SBOX6_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [6*LANES-1:0]   st;
    logic [6*LANES-1:0]   st_next;
    logic [CNT_W-1:0]     cnt;
    logic                 abort_req;

`ifdef SBOX6_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Chi-like 3-bit nonlinear map used on both halves of the isomorphic image.
    function automatic logic [2:0] f3(input logic [2:0] c);
        return {c[1] ^ (c[0] & ~c[2]),
                c[0] ^ (c[2] & ~c[1]),
                c[2] ^ (c[1] & ~c[0])};
    endfunction

    function automatic logic [5:0] sbox(input logic [5:0] a);
        logic [5:0] w;
        logic [5:0] p;
        logic [2:0] t;
        w[0] = a[5];
        w[1] = a[4] ^ a[5];
        w[2] = a[1] ^ a[2] ^ a[5];
        w[3] = a[2] ^ a[4] ^ a[5];
        w[4] = a[0] ^ a[1];
        w[5] = a[0] ^ a[3];
        t      = f3(w[2:0] ^ w[5:3]);
        p[2:0] = f3(w[2:0]) ^ t;
        p[5:3] = f3(w[5:3]) ^ t;
        return {p[0] ^ p[2] ^ p[3],
                p[0] ^ p[4],
                p[2],
                p[1] ^ p[2] ^ p[5],
                p[0] ^ p[1] ^ p[2] ^ p[4],
                p[0]};
    endfunction

    // NOTE: give every combinationally assigned variable a default first so no latch is inferred.
    always_comb begin
        st_next = '0;
        for (int i = 0; i < LANES; i++) begin
            st_next[6*i +: 6] = sbox(st[6*i +: 6]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: st is reset too, because out_data mirrors it and must read 0 after reset.
            state     <= IDLE;
            st        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st       <= in_data;
                        cnt      <= in_rounds;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_rounds == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (abort_req) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        st  <= st_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Abort wins over consumption; either way the result is dropped from out_valid.
                    if (abort_req || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = st;

endmodule
